// File: rtl/multicycle_pkg.sv
// Shared types and constants for the multicycle LEGv8 control path.
// States, instruction classes, opcodes and datapath select encodings.
package multicycle_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_JUMP    = 4'd9,
    S_HALT    = 4'd10
  } state_t;

  typedef enum logic [2:0] {
    C_LDUR,
    C_STUR,
    C_RTYPE,
    C_CBZ,
    C_B,
    C_ILLEGAL
  } iclass_t;

  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;
  localparam logic [5:0]  OP_B    = 6'b000101;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_ORR  = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_PASS = 4'b0111;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_IMM4 = 2'b11;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

endpackage

// File: rtl/multicycle_controller_opdecoder.sv
// Opcode to instruction class and R-type ALU operation.
// Shared by the single-cycle and multicycle control paths.
module opdecoder
  import multicycle_pkg::*;
(
  input  logic [10:0] op,
  output iclass_t     iclass,
  output logic [3:0]  alu_ctl
);

  always_comb begin
    iclass  = C_ILLEGAL;
    alu_ctl = ALU_ADD;
    unique case (1'b1)
      (op == OP_LDUR): iclass = C_LDUR;
      (op == OP_STUR): iclass = C_STUR;
      (op == OP_ADD): begin
        iclass  = C_RTYPE;
        alu_ctl = ALU_ADD;
      end
      (op == OP_SUB): begin
        iclass  = C_RTYPE;
        alu_ctl = ALU_SUB;
      end
      (op == OP_AND): begin
        iclass  = C_RTYPE;
        alu_ctl = ALU_AND;
      end
      (op == OP_ORR): begin
        iclass  = C_RTYPE;
        alu_ctl = ALU_ORR;
      end
      (op[10:3] == OP_CBZ): iclass = C_CBZ;
      (op[10:5] == OP_B):   iclass = C_B;
      default: iclass = C_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Control FSM for the multicycle LEGv8 core: sequences PC, IR,
// operand latches and ALUOut over a shared instruction/data memory.
module multicycle_controller
  import multicycle_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [10:0]      op,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ir_write,
  output logic             adr_src,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_write,
  output logic             reg2loc,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [3:0]       alu_control,
  output logic [1:0]       result_src,
  output logic             illegal,
  output logic [CNT_W-1:0] retired,
  output logic [3:0]       state_o
);

  state_t     state;
  state_t     nxt;
  iclass_t    cls;
  logic [3:0] rtype_alu;
  logic       retire;

  opdecoder u_dec (
    .op      (op),
    .iclass  (cls),
    .alu_ctl (rtype_alu)
  );

  always_comb begin
    nxt = S_FETCH;
    case (state)
      S_FETCH:  nxt = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (cls)
          C_LDUR, C_STUR: nxt = S_MEMADR;
          C_RTYPE:        nxt = S_EXECUTE;
          C_CBZ:          nxt = S_BRANCH;
          C_B:            nxt = S_JUMP;
          default:        nxt = S_HALT;
        endcase
      end
      S_MEMADR: begin
        if (cls == C_STUR)      nxt = S_MEMWR;
        else if (cls == C_LDUR) nxt = S_MEMRD;
        else                    nxt = S_FETCH;
      end
      S_MEMRD:   nxt = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:   nxt = S_FETCH;
      S_MEMWR:   nxt = mem_ready ? S_FETCH : S_MEMWR;
      S_EXECUTE: nxt = S_ALUWB;
      S_ALUWB:   nxt = S_FETCH;
      S_BRANCH:  nxt = S_FETCH;
      S_JUMP:    nxt = S_FETCH;
      S_HALT:    nxt = S_HALT;
      default:   nxt = S_FETCH;
    endcase
  end

  // A store retires only on the cycle its write is accepted
  assign retire = (state == S_MEMWB) || (state == S_ALUWB) ||
                  (state == S_BRANCH) || (state == S_JUMP) ||
                  ((state == S_MEMWR) && mem_ready);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_FETCH;
      illegal <= 1'b0;
      retired <= '0;
    end else begin
      state <= nxt;
      if (nxt == S_HALT) illegal <= 1'b1;
      if (retire) retired <= retired + CNT_W'(1);
    end
  end

  // Outputs are forced low while reset is held, not just after an edge
  always_comb begin
    pc_write    = 1'b0;
    ir_write    = 1'b0;
    adr_src     = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    reg_write   = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = SRCB_REG;
    alu_control = ALU_AND;
    result_src  = RES_ALUOUT;
    if (reset) begin
      case (state)
        S_FETCH: begin
          mem_read    = 1'b1;
          alu_src_b   = SRCB_FOUR;
          alu_control = ALU_ADD;
          result_src  = RES_ALU;
          ir_write    = mem_ready;
          pc_write    = mem_ready;
        end
        S_DECODE: begin
          alu_src_b   = SRCB_IMM4;
          alu_control = ALU_ADD;
        end
        S_MEMADR: begin
          alu_src_a   = 1'b1;
          alu_src_b   = SRCB_IMM;
          alu_control = ALU_ADD;
        end
        S_MEMRD: begin
          adr_src  = 1'b1;
          mem_read = 1'b1;
        end
        S_MEMWB: begin
          result_src = RES_MEM;
          reg_write  = 1'b1;
        end
        S_MEMWR: begin
          adr_src   = 1'b1;
          mem_write = 1'b1;
        end
        S_EXECUTE: begin
          alu_src_a   = 1'b1;
          alu_control = rtype_alu;
        end
        S_ALUWB: reg_write = 1'b1;
        S_BRANCH: begin
          alu_src_a   = 1'b1;
          alu_control = ALU_PASS;
          pc_write    = zero;
        end
        S_JUMP:  pc_write = 1'b1;
        default: ;
      endcase
    end
  end

  assign reg2loc = reset && ((cls == C_STUR) || (cls == C_CBZ)) &&
                   (state != S_FETCH) && (state != S_HALT);

  assign state_o = state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: vector table, corner sequences,
// and random instruction stream against a cycle-count model.
module tb_multicycle_controller;

  localparam logic [10:0] LD  = 11'b11111000010;
  localparam logic [10:0] ST  = 11'b11111000000;
  localparam logic [10:0] ADD = 11'b10001011000;
  localparam logic [10:0] SUB = 11'b11001011000;
  localparam logic [10:0] AND = 11'b10001010000;
  localparam logic [10:0] ORR = 11'b10101010000;
  localparam logic [10:0] CBZ = 11'b10110100101;
  localparam logic [10:0] BOP = 11'b00010111011;
  localparam logic [10:0] BAD = 11'b11111111111;

  // {pcw,irw,adr,mrd,mwr,rgw,r2l,asa,asb[1:0],res[1:0]}
  localparam logic [11:0] F1   = 12'b1101_0000_0110;
  localparam logic [11:0] F0   = 12'b0001_0000_0110;
  localparam logic [11:0] DEC0 = 12'b0000_0000_1100;
  localparam logic [11:0] DEC1 = 12'b0000_0010_1100;
  localparam logic [11:0] MA0  = 12'b0000_0001_1000;
  localparam logic [11:0] MA1  = 12'b0000_0011_1000;
  localparam logic [11:0] MRD  = 12'b0011_0000_0000;
  localparam logic [11:0] MWB  = 12'b0000_0100_0001;
  localparam logic [11:0] MWR  = 12'b0010_1010_0000;
  localparam logic [11:0] EX   = 12'b0000_0001_0000;
  localparam logic [11:0] AWB  = 12'b0000_0100_0000;
  localparam logic [11:0] BR1  = 12'b1000_0011_0000;
  localparam logic [11:0] BR0  = 12'b0000_0011_0000;
  localparam logic [11:0] JMP  = 12'b1000_0000_0000;

  typedef struct {
    logic [10:0] op;
    logic        mr;
    logic        z;
    logic [3:0]  st;
    logic [11:0] ctl;
    logic [3:0]  alu;
    logic [31:0] ret;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] op;
  logic        zero;
  logic        mem_ready;
  logic        pc_write, ir_write, adr_src, mem_read, mem_write;
  logic        reg_write, reg2loc, alu_src_a, illegal;
  logic [1:0]  alu_src_b, result_src;
  logic [3:0]  alu_control, state_o;
  logic [31:0] retired;

  int n_chk = 0;
  int n_fail = 0;

  logic [11:0] s_ctl;
  logic [3:0]  s_st, s_alu;
  logic [31:0] s_ret;
  logic        s_ill;

  vec_t tbl[32];

  always #5 clk = ~clk;

  multicycle_controller #(.CNT_W(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .op          (op),
    .zero        (zero),
    .mem_ready   (mem_ready),
    .pc_write    (pc_write),
    .ir_write    (ir_write),
    .adr_src     (adr_src),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .reg_write   (reg_write),
    .reg2loc     (reg2loc),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .alu_control (alu_control),
    .result_src  (result_src),
    .illegal     (illegal),
    .retired     (retired),
    .state_o     (state_o)
  );

  function automatic vec_t mk(input logic [10:0] o, input logic m,
                              input logic z, input logic [3:0] st,
                              input logic [11:0] c, input logic [3:0] a,
                              input logic [31:0] r);
    vec_t v;
    v.op = o; v.mr = m; v.z = z; v.st = st;
    v.ctl = c; v.alu = a; v.ret = r;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic grab();
    s_ctl = {pc_write, ir_write, adr_src, mem_read, mem_write,
             reg_write, reg2loc, alu_src_a, alu_src_b, result_src};
    s_st  = state_o;
    s_alu = alu_control;
    s_ret = retired;
    s_ill = illegal;
  endtask

  task automatic cyc(input logic [10:0] o, input logic m, input logic z);
    op = o; mem_ready = m; zero = z;
    @(negedge clk);
    grab();
    @(posedge clk);
    #1;
  endtask

  task automatic async_reset(input string nm);
    reset = 1'b0;
    #1;
    grab();
    chk({nm, " state"}, 64'(s_st), 64'd0);
    chk({nm, " ctl"}, 64'(s_ctl), 64'd0);
    chk({nm, " alu"}, 64'(s_alu), 64'd0);
    chk({nm, " retired"}, 64'(s_ret), 64'd0);
    chk({nm, " illegal"}, 64'(s_ill), 64'd0);
    @(posedge clk);
    #3;
    reset = 1'b1;
  endtask

  initial begin
    logic [10:0] rop;
    logic        mq[$];
    logic        zq[$];
    int          cls, wf, wd, nf, pcw, irw, mrd, mwr, rgw;
    int          e_pcw, e_mrd, e_mwr, e_rgw;
    logic [31:0] exp_ret;

    tbl[0]  = mk(LD,  1, 0, 0, F1,   2, 0);
    tbl[1]  = mk(LD,  1, 0, 1, DEC0, 2, 0);
    tbl[2]  = mk(LD,  1, 0, 2, MA0,  2, 0);
    tbl[3]  = mk(LD,  1, 0, 3, MRD,  0, 0);
    tbl[4]  = mk(LD,  1, 0, 4, MWB,  0, 0);
    tbl[5]  = mk(SUB, 1, 0, 0, F1,   2, 1);
    tbl[6]  = mk(SUB, 1, 0, 1, DEC0, 2, 1);
    tbl[7]  = mk(SUB, 1, 0, 6, EX,   6, 1);
    tbl[8]  = mk(SUB, 1, 0, 7, AWB,  0, 1);
    tbl[9]  = mk(ORR, 1, 0, 0, F1,   2, 2);
    tbl[10] = mk(ORR, 1, 0, 1, DEC0, 2, 2);
    tbl[11] = mk(ORR, 1, 0, 6, EX,   1, 2);
    tbl[12] = mk(ORR, 1, 0, 7, AWB,  0, 2);
    tbl[13] = mk(CBZ, 1, 1, 0, F1,   2, 3);
    tbl[14] = mk(CBZ, 1, 1, 1, DEC1, 2, 3);
    tbl[15] = mk(CBZ, 1, 1, 8, BR1,  7, 3);
    tbl[16] = mk(CBZ, 1, 0, 0, F1,   2, 4);
    tbl[17] = mk(CBZ, 1, 0, 1, DEC1, 2, 4);
    tbl[18] = mk(CBZ, 1, 0, 8, BR0,  7, 4);
    tbl[19] = mk(BOP, 1, 0, 0, F1,   2, 5);
    tbl[20] = mk(BOP, 1, 0, 1, DEC0, 2, 5);
    tbl[21] = mk(BOP, 1, 0, 9, JMP,  0, 5);
    tbl[22] = mk(ST,  0, 0, 0, F0,   2, 6);
    tbl[23] = mk(ST,  0, 0, 0, F0,   2, 6);
    tbl[24] = mk(ST,  0, 0, 0, F0,   2, 6);
    tbl[25] = mk(ST,  1, 0, 0, F1,   2, 6);
    tbl[26] = mk(ST,  1, 0, 1, DEC1, 2, 6);
    tbl[27] = mk(ST,  1, 0, 2, MA1,  2, 6);
    tbl[28] = mk(ST,  0, 0, 5, MWR,  0, 6);
    tbl[29] = mk(ST,  0, 0, 5, MWR,  0, 6);
    tbl[30] = mk(ST,  1, 0, 5, MWR,  0, 6);
    tbl[31] = mk(LD,  1, 0, 0, F1,   2, 7);

    reset = 1'b0; op = LD; zero = 1'b0; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    grab();
    chk("reset state", 64'(s_st), 64'd0);
    chk("reset ctl", 64'(s_ctl), 64'd0);
    chk("reset retired", 64'(s_ret), 64'd0);
    chk("reset illegal", 64'(s_ill), 64'd0);
    reset = 1'b1;

    for (int i = 0; i < 32; i++) begin
      cyc(tbl[i].op, tbl[i].mr, tbl[i].z);
      chk($sformatf("vec%0d state", i), 64'(s_st), 64'(tbl[i].st));
      chk($sformatf("vec%0d ctl", i), 64'(s_ctl), 64'(tbl[i].ctl));
      chk($sformatf("vec%0d alu", i), 64'(s_alu), 64'(tbl[i].alu));
      chk($sformatf("vec%0d retired", i), 64'(s_ret), 64'(tbl[i].ret));
    end

    // carry the pending LDUR into MEMRD, then reset it away
    cyc(LD, 1, 0);
    cyc(LD, 0, 0);
    cyc(LD, 0, 0);
    grab();
    chk("memrd before reset", 64'(s_st), 64'd3);
    chk("memrd retired", 64'(s_ret), 64'd7);
    async_reset("mid-memrd");
    cyc(LD, 1, 0);
    chk("post-reset fetch", 64'(s_ctl), 64'(F1));
    chk("post-reset retired", 64'(s_ret), 64'd0);
    cyc(LD, 0, 0);
    cyc(LD, 0, 0);
    async_reset("second reset");

    cyc(ADD, 1, 0);
    cyc(ADD, 1, 0);
    cyc(ADD, 1, 0);
    chk("add alu", 64'(s_alu), 64'h2);
    cyc(ADD, 1, 0);
    cyc(BAD, 1, 0);
    chk("bad fetch retired", 64'(s_ret), 64'd1);
    cyc(BAD, 1, 0);
    chk("bad decode", 64'(s_st), 64'd1);
    for (int i = 0; i < 20; i++) begin
      cyc(BAD, 1'($urandom % 2), 1'($urandom % 2));
      chk($sformatf("halt%0d state", i), 64'(s_st), 64'd10);
      chk($sformatf("halt%0d illegal", i), 64'(s_ill), 64'd1);
      chk($sformatf("halt%0d ctl", i), 64'(s_ctl), 64'd0);
    end
    #2;
    async_reset("halt reset");

    exp_ret = 32'd0;
    for (int n = 0; n < 40; n++) begin
      cls = int'($urandom_range(0, 7));
      case (cls)
        0: rop = LD;
        1: rop = ST;
        2: rop = ADD;
        3: rop = SUB;
        4: rop = AND;
        5: rop = ORR;
        6: rop = {8'b10110100, 3'($urandom)};
        default: rop = {6'b000101, 5'($urandom)};
      endcase
      wf = ($urandom % 3 == 0) ? int'($urandom_range(1, 3)) : 0;
      wd = (cls <= 1 && $urandom % 2 == 0) ? int'($urandom_range(1, 3)) : 0;
      mq.delete();
      zq.delete();
      repeat (wf) mq.push_back(1'b0);
      mq.push_back(1'b1);
      mq.push_back(1'($urandom));
      if (cls <= 1) begin
        mq.push_back(1'($urandom));
        repeat (wd) mq.push_back(1'b0);
        mq.push_back(1'b1);
        if (cls == 0) mq.push_back(1'($urandom));
      end else if (cls <= 5) begin
        mq.push_back(1'($urandom));
        mq.push_back(1'($urandom));
      end else begin
        mq.push_back(1'($urandom));
      end
      for (int i = 0; i < mq.size(); i++) zq.push_back(1'($urandom));

      e_pcw = 1 + ((cls == 7) ? 1 : 0) +
              ((cls == 6 && zq[wf + 2]) ? 1 : 0);
      e_mrd = wf + 1 + ((cls == 0) ? wd + 1 : 0);
      e_mwr = (cls == 1) ? wd + 1 : 0;
      e_rgw = (cls == 0 || (cls >= 2 && cls <= 5)) ? 1 : 0;

      nf = 0; pcw = 0; irw = 0; mrd = 0; mwr = 0; rgw = 0;
      for (int i = 0; i < mq.size(); i++) begin
        cyc(rop, mq[i], zq[i]);
        if (s_st == 4'd0) nf++;
        pcw += int'(s_ctl[11]);
        irw += int'(s_ctl[10]);
        mrd += int'(s_ctl[8]);
        mwr += int'(s_ctl[7]);
        rgw += int'(s_ctl[6]);
      end
      exp_ret = exp_ret + 32'd1;
      grab();
      chk($sformatf("rnd%0d fetch cycles", n), 64'(nf), 64'(wf + 1));
      chk($sformatf("rnd%0d pc_write", n), 64'(pcw), 64'(e_pcw));
      chk($sformatf("rnd%0d ir_write", n), 64'(irw), 64'd1);
      chk($sformatf("rnd%0d mem_read", n), 64'(mrd), 64'(e_mrd));
      chk($sformatf("rnd%0d mem_write", n), 64'(mwr), 64'(e_mwr));
      chk($sformatf("rnd%0d reg_write", n), 64'(rgw), 64'(e_rgw));
      chk($sformatf("rnd%0d back to fetch", n), 64'(s_st), 64'd0);
      chk($sformatf("rnd%0d retired", n), 64'(s_ret), 64'(exp_ret));
    end
    chk("random illegal", 64'(illegal), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Control FSM for the multicycle LEGv8 core. It replaces the single-cycle decoder.
- Sequences the architectural registers over several cycles per instruction. These are the PC flopr, the IR, the A/B operand latches and ALUOut.
- Drives enables and mux selects into a datapath with one shared instruction/data memory.
- Handles a memory-ready handshake, detects illegal opcodes and counts retired instructions.

Parameters:
CNT_W, 32, width of the retired-instruction counter.

Ports:
clk  input  1  clock; rising edge active.
reset  input  1  asynchronous, active-low reset; 0 resets the block immediately.
op  input  11  IR[31:21]; valid from DECODE onward.
zero  input  1  ALU zero flag of the current cycle.
mem_ready  input  1  memory completes the current access this cycle.
pc_write  output  1  PC flopr enable.
ir_write  output  1  IR enable.
adr_src  output  1  memory address select: 0 = PC, 1 = ALUOut.
mem_read  output  1  memory read strobe.
mem_write  output  1  memory write strobe.
reg_write  output  1  register file write enable.
reg2loc  output  1  read port 2 address select: 1 = Rt, 0 = Rm.
alu_src_a  output  1  ALU A select: 0 = PC, 1 = A latch.
alu_src_b  output  2  ALU B select: 00 = B latch, 01 = constant 4, 10 = sign-extended imm, 11 = sign-extended imm<<2.
alu_control  output  4  0000 AND, 0001 ORR, 0010 add, 0110 sub, 0111 pass B.
result_src  output  2  write-back/PC source: 00 = ALUOut, 01 = memory data, 10 = ALU result.
illegal  output  1  sticky; set on an undecodable opcode.
retired  output  CNT_W  count of completed instructions.
state_o  output  4  current state, for debug and bench.

Behaviour:
- Reset (reset=0):
  - state = FETCH, illegal = 0, retired = 0.
  - All strobes and enables 0; selects 0.
  - Asynchronous: takes effect immediately, including mid-instruction. A partially executed instruction is discarded.
- Moore outputs, except two combinational terms:
  - pc_write in FETCH and BRANCH depends on mem_ready/zero.
  - reg2loc is 1 when op is STUR or CBZ, in every state except FETCH and HALT.
  - All signals not listed for a state below are 0.
- Opcode decode:
  - LDUR 11111000010, STUR 11111000000.
  - ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000.
  - CBZ 10110100xxx, B 000101xxxxx.
  - Anything else is illegal.
- FETCH (0):
  - adr_src=0, mem_read=1, alu_src_a=0, alu_src_b=01, alu_control=add, result_src=10.
  - ir_write = pc_write = mem_ready.
  - Stay while mem_ready=0; go to DECODE when it is 1.
- DECODE (1):
  - alu_src_a=0, alu_src_b=11, add. This places the branch target in ALUOut.
  - Next state: LDUR/STUR -> MEMADR; R-type -> EXECUTE; CBZ -> BRANCH; B -> JUMP; illegal -> HALT.
- MEMADR (2):
  - alu_src_a=1, alu_src_b=10, add.
  - Next: MEMRD for LDUR, MEMWR for STUR.
- MEMRD (3): adr_src=1, mem_read=1. Stay until mem_ready=1, then MEMWB.
- MEMWB (4): result_src=01, reg_write=1. Next FETCH; retire.
- MEMWR (5):
  - adr_src=1, mem_write=1, held while waiting.
  - Stay until mem_ready=1, then FETCH; retire.
- EXECUTE (6): alu_src_a=1, alu_src_b=00, alu_control per op. Next ALUWB.
- ALUWB (7): result_src=00, reg_write=1. Next FETCH; retire.
- BRANCH (8):
  - alu_src_a=1, alu_src_b=00, alu_control=pass B, result_src=00.
  - pc_write=zero.
  - Next FETCH; retire whether or not the branch is taken.
- JUMP (9): result_src=00, pc_write=1. Next FETCH; retire.
- HALT (10):
  - Set illegal=1; all outputs 0.
  - Remain until reset. This is the only exit.
- Retired counter:
  - Increments on the clock edge that leaves a retiring state.
  - Wraps modulo 2^CNT_W without saturation.
- CPI: LDUR 5, STUR 4, R-type 4, CBZ 3, B 3. Each cycle with mem_ready=0 adds one cycle.
- Encodings 11–15 are unreachable; if entered, the next state is FETCH.

Decomposition:
- Package multicycle_pkg holds:
  - a state_t enum with explicit 4-bit encodings as above;
  - opcode constants;
  - alu_control constants;
  - alu_src_b and result_src constants.
- One sub-module, opdecoder:
  - combinational op -> instruction class (LDUR, STUR, RTYPE, CBZ, B, ILLEGAL) and R-type alu_control;
  - shared with the single-cycle path.

Test Plan:
- Reset and LDUR:
  - Stimulus: hold reset=0, release; mem_ready=1, op=11111000010.
  - Response: state sequence 0,1,2,3,4,0; reg_write=1 only in state 4; retired=1; pc_write=1 only in FETCH.
- SUB then ORR, mem_ready=1:
  - EXECUTE drives alu_control 0110, then 0001.
  - Each instruction takes 4 cycles; retired=2.
- CBZ:
  - zero=1 in BRANCH gives pc_write=1; zero=0 gives pc_write=0.
  - Both return to FETCH and both increment retired.
  - reg2loc=1 in DECODE and BRANCH.
- Wait states:
  - mem_ready=0 for 3 cycles in FETCH, then STUR with mem_ready=0 for 2 cycles in MEMWR.
  - FETCH holds with ir_write=pc_write=0; mem_write stays 1 for 3 cycles; retired increments once.
- Illegal op 11111111111:
  - DECODE -> HALT; illegal=1 persists for 20 cycles regardless of mem_ready.
  - Asserting reset clears illegal, retired and state immediately, without waiting for clk.
- Reset mid-MEMRD: all outputs 0 immediately; after release, FETCH begins and retired=0.
